// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - buzzer note arbiter: melody tempo generation with pre-emptive sound effects
// Effects freeze the melody (mel_en high, no beat) and resume it at the same note when done.
module sound_scheduler #(
  parameter int BEAT_DIV  = 12_500_000,
  parameter int SFX_BEATS = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_music_on,
  input  logic [21:0] i_mel_div,
  input  logic        i_sfx_req,
  input  logic [1:0]  i_sfx_id,
  input  logic        i_mute,
  output logic        o_mel_en,
  output logic        o_beat,
  output logic [21:0] o_note_div,
  output logic        o_sfx_busy,
  output logic        o_sfx_done
);

  localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BEAT_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    SFX_LEN  = 4'(SFX_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEL  = 2'd1,
    ST_SFX  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_rem;
  logic [21:0]   r_tone;
  logic          r_mel_en;
  logic          r_beat;
  logic [21:0]   r_note_div;
  logic          r_sfx_busy;
  logic          r_sfx_done;

  logic [21:0]   w_req_tone;
  logic          w_cnt_last;
  logic [CW-1:0] w_cnt_next;
  logic [21:0]   w_mel_note;
  logic [21:0]   w_sfx_note;
  logic [21:0]   w_req_note;

  always_comb begin
    w_req_tone = 22'd127551;
    case (i_sfx_id)
      2'd0: w_req_tone = 22'd127551;
      2'd1: w_req_tone = 22'd113636;
      2'd2: w_req_tone = 22'd191571;
      2'd3: w_req_tone = 22'd151515;
      default: w_req_tone = 22'd127551;
    endcase
  end

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_cnt_next = w_cnt_last ? '0 : r_cnt + CNT_ONE;
  // Mute only gates the output register; sequencing never sees it.
  assign w_mel_note = i_mute ? 22'd0 : i_mel_div;
  assign w_sfx_note = i_mute ? 22'd0 : r_tone;
  assign w_req_note = i_mute ? 22'd0 : w_req_tone;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rem      <= 4'd0;
      r_tone     <= 22'd0;
      r_mel_en   <= 1'b0;
      r_beat     <= 1'b0;
      r_note_div <= 22'd0;
      r_sfx_busy <= 1'b0;
      r_sfx_done <= 1'b0;
    end else begin
      r_beat     <= 1'b0;
      r_sfx_done <= 1'b0;
      if (i_sfx_req) begin
        // Accept or retrigger from any state, including the final terminal count.
        r_state    <= ST_SFX;
        r_cnt      <= '0;
        r_rem      <= SFX_LEN;
        r_tone     <= w_req_tone;
        r_mel_en   <= 1'b1;
        r_sfx_busy <= 1'b1;
        r_note_div <= w_req_note;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (i_music_on) begin
              r_state    <= ST_MEL;
              r_mel_en   <= 1'b1;
              r_note_div <= w_mel_note;
            end else begin
              r_mel_en   <= 1'b0;
              r_note_div <= 22'd0;
            end
          end
          ST_MEL: begin
            if (!i_music_on) begin
              r_state    <= ST_IDLE;
              r_cnt      <= '0;
              r_mel_en   <= 1'b0;
              r_note_div <= 22'd0;
            end else begin
              r_cnt      <= w_cnt_next;
              r_beat     <= w_cnt_last;
              r_note_div <= w_mel_note;
            end
          end
          ST_SFX: begin
            if (w_cnt_last && (r_rem == 4'd1)) begin
              r_cnt      <= '0;
              r_rem      <= 4'd0;
              r_sfx_busy <= 1'b0;
              r_sfx_done <= 1'b1;
              if (i_music_on) begin
                r_state    <= ST_MEL;
                r_mel_en   <= 1'b1;
                r_note_div <= w_mel_note;
              end else begin
                r_state    <= ST_IDLE;
                r_mel_en   <= 1'b0;
                r_note_div <= 22'd0;
              end
            end else begin
              r_cnt      <= w_cnt_next;
              r_note_div <= w_sfx_note;
              if (w_cnt_last) begin
                r_rem <= r_rem - 4'd1;
              end
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mel_en   <= 1'b0;
            r_note_div <= 22'd0;
            r_sfx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_mel_en   = r_mel_en;
  assign o_beat     = r_beat;
  assign o_note_div = r_note_div;
  assign o_sfx_busy = r_sfx_busy;
  assign o_sfx_done = r_sfx_done;

endmodule

// File: tb/tb_sound_scheduler.sv
// tb/tb_sound_scheduler.sv - self-checking bench for sound_scheduler
// Reference model tracks mode and cycles elapsed since mode entry.
module tb_sound_scheduler;

  localparam int BD = 4;
  localparam int SB = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_music_on = 1'b0;
  logic [21:0] i_mel_div = 22'd0;
  logic        i_sfx_req = 1'b0;
  logic [1:0]  i_sfx_id = 2'd0;
  logic        i_mute = 1'b0;
  logic        o_mel_en;
  logic        o_beat;
  logic [21:0] o_note_div;
  logic        o_sfx_busy;
  logic        o_sfx_done;

  sound_scheduler #(.BEAT_DIV(BD), .SFX_BEATS(SB)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_music_on (i_music_on),
    .i_mel_div  (i_mel_div),
    .i_sfx_req  (i_sfx_req),
    .i_sfx_id   (i_sfx_id),
    .i_mute     (i_mute),
    .o_mel_en   (o_mel_en),
    .o_beat     (o_beat),
    .o_note_div (o_note_div),
    .o_sfx_busy (o_sfx_busy),
    .o_sfx_done (o_sfx_done)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Model: 0 = idle, 1 = melody, 2 = effect
  int          m_mode = 0;
  int          m_elapsed = 0;
  logic [21:0] m_tone = 22'd0;
  logic        e_en = 1'b0, e_beat = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [21:0] e_note = 22'd0;

  logic [25:0] got;
  assign got = {o_mel_en, o_beat, o_sfx_busy, o_sfx_done, o_note_div};

  function automatic logic [21:0] tone_of(input logic [1:0] id);
    case (id)
      2'd0: return 22'd127551;
      2'd1: return 22'd113636;
      2'd2: return 22'd191571;
      default: return 22'd151515;
    endcase
  endfunction

  function automatic logic [25:0] exp_vec();
    return {e_en, e_beat, e_busy, e_done, e_note};
  endfunction

  task automatic model_step();
    e_beat = 1'b0;
    e_done = 1'b0;
    if (i_rst) begin
      m_mode = 0;
      m_elapsed = 0;
      m_tone = 22'd0;
    end else if (i_sfx_req) begin
      m_mode = 2;
      m_elapsed = 0;
      m_tone = tone_of(i_sfx_id);
    end else if (m_mode == 0) begin
      if (i_music_on) begin
        m_mode = 1;
        m_elapsed = 0;
      end
    end else if (m_mode == 1) begin
      if (!i_music_on) begin
        m_mode = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed % BD == 0) e_beat = 1'b1;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == SB * BD) begin
        e_done = 1'b1;
        m_mode = i_music_on ? 1 : 0;
        m_elapsed = 0;
      end
    end
    e_en   = (m_mode != 0);
    e_busy = (m_mode == 2);
    if (i_rst || i_mute || m_mode == 0) e_note = 22'd0;
    else if (m_mode == 1)               e_note = i_mel_div;
    else                                e_note = m_tone;
  endtask

  task automatic tick(input logic req, input logic [1:0] id);
    i_sfx_req = req;
    i_sfx_id  = id;
    @(posedge i_clk);
    model_step();
    #1;
    i_sfx_req = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_music_on = 1'b1;
    tick(1'b1, 2'd2);
    tick(1'b0, 2'd0);
    if (got !== 26'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", got);
    end
    checks++;
    if (got !== exp_vec()) begin
      errors++; $display("FAIL reset_model got=%h exp=%h", got, exp_vec());
    end
    checks++;
    i_rst = 1'b0;
    i_music_on = 1'b0;
    tick(1'b0, 2'd0);
  endtask

  task automatic test_melody();
    int beats = 0;
    int first = -1;
    i_music_on = 1'b1;
    i_mel_div = 22'd127551;
    for (int i = 0; i <= 12; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL melody cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
      if (o_beat) begin
        beats++;
        if (first < 0) first = i;
      end
    end
    if (beats !== 3 || first !== 4) begin
      errors++; $display("FAIL melody_beats got=%0d first=%0d exp=3 first=4", beats, first);
    end
    checks++;
    if (o_note_div !== 22'd127551 || o_mel_en !== 1'b1) begin
      errors++; $display("FAIL melody_note got=%0d en=%b exp=127551 en=1", o_note_div, o_mel_en);
    end
    checks++;
  endtask

  task automatic test_sfx_in_mel();
    int busy = 0, beats = 0, dones = 0, first = -1;
    tick(1'b1, 2'd2);
    if (o_note_div !== 22'd191571 || o_sfx_busy !== 1'b1 || o_mel_en !== 1'b1) begin
      errors++; $display("FAIL sfx_start got=%0d busy=%b en=%b exp=191571 busy=1 en=1", o_note_div, o_sfx_busy, o_mel_en);
    end
    checks++;
    busy += o_sfx_busy;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL sfx_mel cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
      busy += o_sfx_busy; beats += o_beat; dones += o_sfx_done;
    end
    if (busy !== 8 || beats !== 0 || dones !== 1) begin
      errors++; $display("FAIL sfx_mel_counts got busy=%0d beats=%0d done=%0d exp busy=8 beats=0 done=1", busy, beats, dones);
    end
    checks++;
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL sfx_resume cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
      if (o_beat && first < 0) first = i;
    end
    if (first !== 4) begin
      errors++; $display("FAIL resume_beat got=%0d exp=4", first);
    end
    checks++;
  endtask

  task automatic test_sfx_idle();
    i_music_on = 1'b0;
    tick(1'b0, 2'd0);
    tick(1'b1, 2'd3);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL sfx_idle cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
    end
    if (o_sfx_done !== 1'b1 || o_mel_en !== 1'b0 || o_note_div !== 22'd0 || o_sfx_busy !== 1'b0) begin
      errors++; $display("FAIL sfx_idle_end got=%h exp done=1 en=0 note=0 busy=0", got);
    end
    checks++;
  endtask

  task automatic test_retrigger();
    int dones = 0, busy_after = 0;
    i_music_on = 1'b1;
    tick(1'b1, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 2'd0);
      dones += o_sfx_done;
    end
    tick(1'b1, 2'd1);
    if (o_note_div !== 22'd113636 || o_sfx_done !== 1'b0) begin
      errors++; $display("FAIL retrig_tone got=%0d done=%b exp=113636 done=0", o_note_div, o_sfx_done);
    end
    checks++;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL retrig cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
      dones += o_sfx_done; busy_after += o_sfx_busy;
    end
    if (dones !== 1 || busy_after !== 7) begin
      errors++; $display("FAIL retrig_counts got done=%0d busy=%0d exp done=1 busy=7", dones, busy_after);
    end
    checks++;
  endtask

  task automatic test_mute();
    int beats = 0, dones = 0, loud = 0;
    i_mute = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL mute_mel cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
      beats += o_beat; loud += (o_note_div != 0);
    end
    tick(1'b1, 2'd1);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL mute_sfx cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
      dones += o_sfx_done; loud += (o_note_div != 0);
    end
    if (beats !== 2 || dones !== 1 || loud !== 0) begin
      errors++; $display("FAIL mute_counts got beats=%0d done=%0d loud=%0d exp 2 1 0", beats, dones, loud);
    end
    checks++;
    i_mute = 1'b0;
  endtask

  task automatic test_final_retrigger();
    tick(1'b1, 2'd2);
    for (int i = 1; i <= 7; i++) tick(1'b0, 2'd0);
    tick(1'b1, 2'd3);
    if (o_sfx_done !== 1'b0 || o_sfx_busy !== 1'b1 || o_note_div !== 22'd151515) begin
      errors++; $display("FAIL final_retrig got=%h exp done=0 busy=1 note=151515", got);
    end
    checks++;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL final_retrig cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    tick(1'b1, 2'd0);
    for (int i = 1; i <= 3; i++) tick(1'b0, 2'd0);
    i_rst = 1'b1;
    tick(1'b0, 2'd0);
    if (got !== 26'd0) begin
      errors++; $display("FAIL reset_mid got=%h exp=0", got);
    end
    checks++;
    i_rst = 1'b0;
    i_music_on = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      tick(1'b0, 2'd0);
      if (got !== exp_vec()) begin
        errors++; $display("FAIL reset_restart cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
      if (o_sfx_done) first = 99;
      if (o_beat && first < 0) first = i;
    end
    if (first !== 4) begin
      errors++; $display("FAIL restart_beat got=%0d exp=4", first);
    end
    checks++;
  endtask

  task automatic test_random();
    logic req;
    for (int i = 0; i < 800; i++) begin
      i_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) i_music_on = ~i_music_on;
      if ($urandom_range(0, 9) == 0)  i_mute = ~i_mute;
      if ($urandom_range(0, 3) == 0)  i_mel_div = 22'($urandom_range(0, 4194303));
      req = ($urandom_range(0, 13) == 0);
      tick(req, 2'($urandom_range(0, 3)));
      if (got !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp_vec());
      end
      checks++;
    end
    i_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_melody();
    test_sfx_in_mel();
    test_sfx_idle();
    test_retrigger();
    test_mute();
    test_final_retrigger();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Arbiter and tempo controller for the single buzzer note path. It runs the background melody sequencer by generating its `mel_en` enable and `beat` advance pulse. One-shot sound effects (hit, score, win) pre-empt the melody, which pauses and then resumes at the note where it stopped. Sits between the melody sequencer / game logic and the buzzer/audio driver that consumes `note_div`.

## Interface
- `BEAT_DIV`, 12_500_000: `clk` cycles per beat (0.125 s at 100 MHz); legal ≥ 2.
- `SFX_BEATS`, 2: length of every sound effect in beats; legal 1..15.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `music_on`  in  1  level; background melody requested.
- `mel_div`  in  22  note divider from the melody sequencer (0 = silence).
- `sfx_req`  in  1  one-cycle pulse; start a sound effect.
- `sfx_id`  in  2  effect tone, sampled with `sfx_req`: 0→127551 (SO), 1→113636 (LA), 2→191571 (DO), 3→151515 (MI).
- `mute`  in  1  level; forces `note_div` to 0 without affecting sequencing.
- `mel_en`  out  1  enable to melody sequencer.
- `beat`  out  1  one-cycle advance pulse to melody sequencer.
- `note_div`  out  22  divider to audio driver.
- `sfx_busy`  out  1  high while an effect is sounding.
- `sfx_done`  out  1  one-cycle pulse when an effect completes.

## Operation
- States: IDLE, MEL, SFX. Reset → IDLE.
- IDLE: `music_on`=1 → MEL; `sfx_req` → SFX (takes priority over `music_on`).
- MEL: `sfx_req` → SFX; else `music_on`=0 → IDLE.
- SFX: `sfx_req` → retrigger (stay SFX, reload tone and duration, no `sfx_done`); else after the last beat → MEL if `music_on`=1, otherwise IDLE.
- Beat counter `cnt`, width ceil(log2(BEAT_DIV)), cleared to 0 on every state entry (including retrigger), counts 0..BEAT_DIV-1 and wraps; counts only in MEL and SFX, held at 0 in IDLE.
- `beat` is asserted only in MEL, on the cnt terminal count. It is never asserted in SFX or IDLE.
- `mel_en` = 1 in MEL and SFX, 0 in IDLE. Holding `mel_en` high with no `beat` freezes the melody position during an effect.
- Effect remaining-beat counter (4 bits): loaded with SFX_BEATS on entry or retrigger, decremented at each cnt terminal in SFX. Exit occurs on the terminal count when its value is 1.
- Tone register: loaded from `sfx_id` on accept.
- `note_div` source: MEL → `mel_div`; SFX → tone register; IDLE → 0. `mute`=1 → 0 regardless of source.
- `sfx_busy` = (state == SFX).

## Timing
- All outputs registered. Reset values: state IDLE, `mel_en` 0, `beat` 0, `note_div` 0, `sfx_busy` 0, `sfx_done` 0, counters 0.
- Reset mid-effect or mid-melody: all outputs return to reset values at the reset edge. No `sfx_done` is issued.
- `sfx_req` sampled at edge k: from edge k, `sfx_busy`=1, `note_div`=tone, and `mel_en`=1.
- Effect end: at edge k+SFX_BEATS·BEAT_DIV, `sfx_busy`=0 and `sfx_done`=1 for exactly one cycle. `note_div` switches to its new source at the same edge.
- MEL entered at edge m: `beat` is high in the single cycle after edges m+BEAT_DIV, m+2·BEAT_DIV, ….
- `note_div` in MEL follows `mel_div` with one-cycle latency.
- `mute` affects `note_div` with one-cycle latency.
- `music_on` falling in MEL: at the next edge the state is IDLE, `mel_en`=0, `note_div`=0, and a pending beat is dropped.
- `music_on` changes during SFX have no effect until the effect ends.
- `sfx_req` in the same cycle as the effect's final terminal count: treated as a retrigger, with no `sfx_done`.

## Test plan
- Reset, then `music_on`=1, BEAT_DIV=4, `mel_div`=127551 → `mel_en`=1 one cycle after; `beat` pulses every 4 cycles, with the first pulse 4 cycles after MEL entry; `note_div`=127551.
- In MEL, `sfx_req` with `sfx_id`=2, SFX_BEATS=2 → `note_div`=191571 and `sfx_busy`=1 for 8 cycles; no `beat` during this time; `sfx_done` pulses once; melody resumes with the next `beat` 4 cycles after return.
- SFX with `music_on`=0 → after 8 cycles the state is IDLE and `note_div`=0, `mel_en`=0, `sfx_done`=1.
- Retrigger: during an effect with `sfx_id`=0, at cycle 5 pulse `sfx_req` with `sfx_id`=1 → `note_div`=113636 immediately; `sfx_busy` extends to 8 cycles after the retrigger; exactly one `sfx_done` is produced.
- `mute`=1 during MEL and during SFX → `note_div`=0, while `beat`/`sfx_done` timing is unchanged.
- Assert `rst` mid-effect → all outputs 0 at the next edge; no `sfx_done`; normal sequencing restarts from IDLE.
